weighted_rr_arbiter: RTL and testbench
======================================

WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 Parameter N_SLAVES, default 4, number of requesting slave ports (>=2).
REQ-002 Parameter DEST_W, default 2, width of destination/master index.
REQ-003 Parameter WEIGHT_W, default 3, width of per-slave packet weight.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 number  in  DEST_W  index of the master this arbiter serves.
REQ-007 m_ready  in  1  master can accept a beat.
REQ-008 s_dest_i  in  N_SLAVES x DEST_W  destination index per slave.
REQ-009 s_valid_i  in  N_SLAVES  beat valid per slave.
REQ-010 s_last  in  N_SLAVES  per-slave last-beat-of-packet flag.
REQ-011 weight_i  in  N_SLAVES x WEIGHT_W  max consecutive packets per grant.
REQ-012 s_ready_o  out  N_SLAVES  per-slave ready.
REQ-013 grant_valid_o  out  1  a slave currently holds the grant.
REQ-014 grant_idx_o  out  clog2(N_SLAVES)  index of granted slave.

Function
REQ-015 Request r[i] SHALL be s_valid_i[i] && (s_dest_i[i] == number).
REQ-016 FSM SHALL have states IDLE, BUSY, HOLD.
REQ-017 IDLE: if any r[i], select first i at or after ptr cyclically; next cycle BUSY, grant_idx_o=i, grant_valid_o=1, pkt_cnt=0, weight latched as max(weight_i[i],1).
REQ-018 IDLE with no request: remain IDLE, s_ready_o all 0, grant_valid_o 0.
REQ-019 Arbitration latency SHALL be exactly one cycle from request visible to s_ready_o asserted.
REQ-020 BUSY: s_ready_o[g]=m_ready (combinational), all other bits 0.
REQ-021 Beat transfer = s_valid_i[g] && s_ready_o[g]; packet end = transfer && s_last[g].
REQ-022 Grant SHALL be locked in BUSY until packet end, irrespective of s_valid_i[g] dropping, s_dest_i[g] or number changing.
REQ-023 On packet end with pkt_cnt+1 < latched weight: pkt_cnt++, next state HOLD.
REQ-024 On packet end with pkt_cnt+1 >= latched weight: ptr=(g+1) mod N_SLAVES, next state IDLE, grant_valid_o 0 next cycle.
REQ-025 HOLD: s_ready_o all 0; if r[g] then BUSY with same g (no re-arbitration); else ptr=(g+1) mod N_SLAVES, IDLE.
REQ-026 A single-beat packet (s_last with first beat) SHALL count as one packet.
REQ-027 weight_i changes during a grant SHALL take effect only at the next IDLE selection.
REQ-028 ptr wrap: after slave N_SLAVES-1 releases, search SHALL start at slave 0.
REQ-029 Slaves not addressing number SHALL never see s_ready_o asserted.
REQ-030 m_ready low in BUSY SHALL stall (no transfer) without losing grant or count.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, ptr=0, pkt_cnt=0, s_ready_o=0, grant_valid_o=0, grant_idx_o=0.
REQ-032 Reset mid-packet SHALL abandon the packet; first arbitration after release starts from slave 0.

Verification
REQ-033 N_SLAVES=2, weights 1, number=0, slave0 then slave1 request dest 0 -> slave0 ready one cycle later; after slave0 s_last, one IDLE cycle, then slave1 ready.
REQ-034 Both slaves request continuously, weights 1, single-beat packets -> grants alternate 0,1,0,1 with IDLE cycle between each.
REQ-035 Slave0 weight 3, slave1 weight 1, both requesting -> three slave0 packets (HOLD between each) then one slave1 packet.
REQ-036 Slave0 drops valid mid-packet, m_ready low for 3 cycles -> grant_idx_o stays 0, no other slave ready until slave0 s_last transfer.
REQ-037 All slaves s_dest_i=1, number=0 -> s_ready_o stays 0, grant_valid_o stays 0.
REQ-038 N_SLAVES=4, rst_n pulsed while slave2 granted -> outputs 0 immediately; with slaves 1,3 requesting after release, slave1 granted first.

Source files
------------

// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter
//   Per-master arbiter choosing among N_SLAVES requesting slave ports. A slave
//   requests this master when it is valid and its destination index equals
//   `number`. Selection is round-robin from a rotating pointer. A granted slave
//   may send up to max(weight,1) consecutive packets before the pointer moves
//   on. The grant stays locked for the whole of a packet.
//
// Ports
//   clk            clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   number         index of the master served by this arbiter
//   m_ready        master can accept a beat
//   s_dest_i       packed per-slave destination index (slave i at [i*DEST_W +: DEST_W])
//   s_valid_i      per-slave beat valid
//   s_last         per-slave last-beat-of-packet flag
//   weight_i       packed per-slave packet weight (slave i at [i*WEIGHT_W +: WEIGHT_W])
//   s_ready_o      per-slave ready (only the granted slave, only while BUSY)
//   grant_valid_o  a slave currently holds the grant (BUSY or HOLD)
//   grant_idx_o    index of the granted slave
module weighted_rr_arbiter #(
  parameter int N_SLAVES = 4,
  parameter int DEST_W   = 2,
  parameter int WEIGHT_W = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DEST_W-1:0]             number,
  input  logic                          m_ready,
  input  logic [N_SLAVES*DEST_W-1:0]    s_dest_i,
  input  logic [N_SLAVES-1:0]           s_valid_i,
  input  logic [N_SLAVES-1:0]           s_last,
  input  logic [N_SLAVES*WEIGHT_W-1:0]  weight_i,
  output logic [N_SLAVES-1:0]           s_ready_o,
  output logic                          grant_valid_o,
  output logic [$clog2(N_SLAVES)-1:0]   grant_idx_o
);

  localparam int IDX_W = $clog2(N_SLAVES);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(N_SLAVES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLAVES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic [IDX_W-1:0]      ptr;
  logic [WEIGHT_W-1:0]   pkt_cnt;
  logic [WEIGHT_W-1:0]   weight_lat;

  logic [DEST_W-1:0]     dest_arr   [N_SLAVES];
  logic [WEIGHT_W-1:0]   weight_arr [N_SLAVES];
  logic [N_SLAVES-1:0]   req;

  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic [IDX_W:0]        cand;
  logic [WEIGHT_W-1:0]   sel_weight;

  logic                  pkt_end;
  logic [WEIGHT_W:0]     cnt_next;
  logic                  more_pkts;
  logic [IDX_W-1:0]      ptr_after_grant;

  // Unpack the flat per-slave buses.
  for (genvar i = 0; i < N_SLAVES; i++) begin : g_unpack
    assign dest_arr[i]   = s_dest_i[i*DEST_W +: DEST_W];
    assign weight_arr[i] = weight_i[i*WEIGHT_W +: WEIGHT_W];
    assign req[i]        = s_valid_i[i] && (dest_arr[i] == number);
  end

  // First requester at or after ptr, cyclically. ptr+k stays below 2*N_SLAVES,
  // so one conditional subtract is enough for the wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (!sel_found && req[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // A zero weight still allows one packet.
  assign sel_weight = (weight_arr[sel_idx] == '0) ? WEIGHT_W'(1) : weight_arr[sel_idx];

  // Transfers only happen while BUSY; the request condition is deliberately
  // not used here so a mid-packet destination change cannot break the lock.
  assign pkt_end   = (state == BUSY) && m_ready && s_valid_i[grant_idx] && s_last[grant_idx];
  assign cnt_next  = {1'b0, pkt_cnt} + 1'b1;
  assign more_pkts = cnt_next < {1'b0, weight_lat};

  assign ptr_after_grant = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  always_comb begin
    s_ready_o = '0;
    if (state == BUSY) begin
      s_ready_o[grant_idx] = m_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
      pkt_cnt     <= '0;
      weight_lat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            state       <= BUSY;
            grant_idx   <= sel_idx;
            grant_valid <= 1'b1;
            pkt_cnt     <= '0;
            weight_lat  <= sel_weight;
          end
        end
        BUSY: begin
          if (pkt_end) begin
            if (more_pkts) begin
              pkt_cnt <= cnt_next[WEIGHT_W-1:0];
              state   <= HOLD;
            end else begin
              ptr         <= ptr_after_grant;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        HOLD: begin
          if (req[grant_idx]) begin
            state <= BUSY;
          end else begin
            ptr         <= ptr_after_grant;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid_o = grant_valid;
  assign grant_idx_o   = grant_idx;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
module tb_weighted_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  number;
  logic        m_ready;
  logic [7:0]  s_dest_i;
  logic [3:0]  s_valid_i;
  logic [3:0]  s_last;
  logic [11:0] weight_i;
  logic [3:0]  s_ready_o;
  logic        grant_valid_o;
  logic [1:0]  grant_idx_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: who owns the master, how many packets it may still send,
  // and whether it is between packets of its allowance.
  int m_owner;
  int m_left;
  int m_ptr;
  bit m_between;

  weighted_rr_arbiter #(
    .N_SLAVES (4),
    .DEST_W   (2),
    .WEIGHT_W (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .number        (number),
    .m_ready       (m_ready),
    .s_dest_i      (s_dest_i),
    .s_valid_i     (s_valid_i),
    .s_last        (s_last),
    .weight_i      (weight_i),
    .s_ready_o     (s_ready_o),
    .grant_valid_o (grant_valid_o),
    .grant_idx_o   (grant_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit mreq(int i);
    return s_valid_i[i] && (s_dest_i[i*2 +: 2] == number);
  endfunction

  function automatic void model_reset();
    m_owner   = -1;
    m_left    = 0;
    m_ptr     = 0;
    m_between = 1'b0;
  endfunction

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    r = 4'b0000;
    if (m_owner >= 0 && !m_between && m_ready) r[m_owner] = 1'b1;
    return r;
  endfunction

  function automatic void model_advance();
    int  o;
    int  w;
    bit  found;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        o = (m_ptr + k) % 4;
        if (!found && mreq(o)) begin
          found     = 1'b1;
          w         = int'(weight_i[o*3 +: 3]);
          m_owner   = o;
          m_left    = (w == 0) ? 1 : w;
          m_between = 1'b0;
        end
      end
    end else if (!m_between) begin
      if (s_valid_i[m_owner] && m_ready && s_last[m_owner]) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
        end else begin
          m_between = 1'b1;
        end
      end
    end else begin
      if (mreq(m_owner)) begin
        m_between = 1'b0;
      end else begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    number    = 2'd0;
    m_ready   = 1'b1;
    s_dest_i  = 8'h00;
    s_valid_i = 4'b0000;
    s_last    = 4'b0000;
    weight_i  = {3'd1, 3'd1, 3'd1, 3'd1};
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    number    = 2'd0;
    m_ready   = 1'b1;
    s_dest_i  = 8'h00;
    s_valid_i = 4'b1111;
    s_last    = 4'b1111;
    weight_i  = {3'd2, 3'd2, 3'd2, 3'd2};
    for (int c = 0; c < 2; c++) begin
      #1;
      n_assert++;
      if (s_ready_o !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ready cycle %0d: got %b expected 0000", c, s_ready_o);
      end
      n_assert++;
      if (grant_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL reset_grant_valid cycle %0d: got %b expected 0", c, grant_valid_o);
      end
      n_assert++;
      if (grant_idx_o !== 2'd0) begin
        n_fail++; $display("FAIL reset_grant_idx cycle %0d: got %0d expected 0", c, grant_idx_o);
      end
      @(negedge clk);
    end
    rst_n     = 1'b1;
    s_valid_i = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_assert++;
      if (s_ready_o !== 4'b0000 || grant_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_request cycle %0d: got ready=%b gv=%b expected ready=0000 gv=0", c, s_ready_o, grant_valid_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_handoff();
    logic [3:0] v_tab [6] = '{4'b0001, 4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0000};
    logic [3:0] l_tab [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    logic [3:0] r_tab [6] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    logic       g_tab [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] i_tab [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      s_valid_i = v_tab[c];
      s_last    = l_tab[c];
      #1;
      n_assert++;
      if (s_ready_o !== r_tab[c]) begin
        n_fail++; $display("FAIL handoff_ready cycle %0d: got %b expected %b", c, s_ready_o, r_tab[c]);
      end
      n_assert++;
      if (grant_valid_o !== g_tab[c]) begin
        n_fail++; $display("FAIL handoff_grant_valid cycle %0d: got %b expected %b", c, grant_valid_o, g_tab[c]);
      end
      if (g_tab[c]) begin
        n_assert++;
        if (grant_idx_o !== i_tab[c]) begin
          n_fail++; $display("FAIL handoff_grant_idx cycle %0d: got %0d expected %0d", c, grant_idx_o, i_tab[c]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alternate();
    logic [3:0] exp_r;
    int         g;
    do_reset();
    s_valid_i = 4'b0011;
    s_last    = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      g     = ((c - 1) / 2) % 2;
      exp_r = (c % 2 == 1) ? (4'b0001 << g) : 4'b0000;
      #1;
      n_assert++;
      if (s_ready_o !== exp_r) begin
        n_fail++; $display("FAIL alternate_ready cycle %0d: got %b expected %b", c, s_ready_o, exp_r);
      end
      n_assert++;
      if (grant_valid_o !== (c % 2 == 1)) begin
        n_fail++; $display("FAIL alternate_grant_valid cycle %0d: got %b expected %b", c, grant_valid_o, (c % 2 == 1));
      end
      if (c % 2 == 1) begin
        n_assert++;
        if (grant_idx_o !== 2'(g)) begin
          n_fail++; $display("FAIL alternate_grant_idx cycle %0d: got %0d expected %0d", c, grant_idx_o, g);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_weight();
    logic [3:0] r_tab [10] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000,
                               4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
    logic       g_tab [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] i_tab [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    do_reset();
    weight_i  = {3'd1, 3'd1, 3'd1, 3'd3};
    s_valid_i = 4'b0011;
    s_last    = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      // Lowering slave 0's weight mid-grant must not shorten the current grant.
      if (c == 3) weight_i = {3'd1, 3'd1, 3'd1, 3'd1};
      #1;
      n_assert++;
      if (s_ready_o !== r_tab[c]) begin
        n_fail++; $display("FAIL weight_ready cycle %0d: got %b expected %b", c, s_ready_o, r_tab[c]);
      end
      n_assert++;
      if (grant_valid_o !== g_tab[c]) begin
        n_fail++; $display("FAIL weight_grant_valid cycle %0d: got %b expected %b", c, grant_valid_o, g_tab[c]);
      end
      if (g_tab[c]) begin
        n_assert++;
        if (grant_idx_o !== i_tab[c]) begin
          n_fail++; $display("FAIL weight_grant_idx cycle %0d: got %0d expected %0d", c, grant_idx_o, i_tab[c]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [3:0] v_tab [10] = '{4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0100,
                               4'b0100, 4'b0101, 4'b0100, 4'b0100, 4'b0000};
    logic [3:0] l_tab [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                               4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
    logic       m_tab [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] d_tab [10] = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00};
    logic [3:0] r_tab [10] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                               4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
    logic       g_tab [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] i_tab [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      s_valid_i = v_tab[c];
      s_last    = l_tab[c];
      m_ready   = m_tab[c];
      s_dest_i  = d_tab[c];
      #1;
      n_assert++;
      if (s_ready_o !== r_tab[c]) begin
        n_fail++; $display("FAIL stall_ready cycle %0d: got %b expected %b", c, s_ready_o, r_tab[c]);
      end
      n_assert++;
      if (grant_valid_o !== g_tab[c]) begin
        n_fail++; $display("FAIL stall_grant_valid cycle %0d: got %b expected %b", c, grant_valid_o, g_tab[c]);
      end
      if (g_tab[c]) begin
        n_assert++;
        if (grant_idx_o !== i_tab[c]) begin
          n_fail++; $display("FAIL stall_grant_idx cycle %0d: got %0d expected %0d", c, grant_idx_o, i_tab[c]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_no_match();
    do_reset();
    number    = 2'd0;
    s_dest_i  = 8'h55;
    s_valid_i = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      s_last = 4'($urandom);
      #1;
      n_assert++;
      if (s_ready_o !== 4'b0000 || grant_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL no_match cycle %0d: got ready=%b gv=%b expected ready=0000 gv=0", c, s_ready_o, grant_valid_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] r_tab [4] = '{4'b0000, 4'b0010, 4'b0000, 4'b1000};
    logic       g_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] i_tab [4] = '{2'd0, 2'd1, 2'd0, 2'd3};
    do_reset();
    s_valid_i = 4'b0100;
    s_last    = 4'b0000;
    #1;
    @(negedge clk);
    #1;
    n_assert++;
    if (s_ready_o !== 4'b0100 || grant_valid_o !== 1'b1 || grant_idx_o !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got ready=%b gv=%b idx=%0d expected ready=0100 gv=1 idx=2", s_ready_o, grant_valid_o, grant_idx_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (s_ready_o !== 4'b0000 || grant_valid_o !== 1'b0 || grant_idx_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got ready=%b gv=%b idx=%0d expected ready=0000 gv=0 idx=0", s_ready_o, grant_valid_o, grant_idx_o);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    s_valid_i = 4'b1010;
    s_last    = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_assert++;
      if (s_ready_o !== r_tab[c]) begin
        n_fail++; $display("FAIL reset_mid_ready cycle %0d: got %b expected %b", c, s_ready_o, r_tab[c]);
      end
      n_assert++;
      if (grant_valid_o !== g_tab[c]) begin
        n_fail++; $display("FAIL reset_mid_grant_valid cycle %0d: got %b expected %b", c, grant_valid_o, g_tab[c]);
      end
      if (g_tab[c]) begin
        n_assert++;
        if (grant_idx_o !== i_tab[c]) begin
          n_fail++; $display("FAIL reset_mid_grant_idx cycle %0d: got %0d expected %0d", c, grant_idx_o, i_tab[c]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_r;
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) number = 2'($urandom);
      if ($urandom_range(0, 29) == 0) weight_i = 12'($urandom);
      for (int i = 0; i < 4; i++) begin
        s_dest_i[i*2 +: 2] = ($urandom_range(0, 9) < 7) ? number : 2'($urandom);
        s_valid_i[i]       = ($urandom_range(0, 9) < 7);
        s_last[i]          = ($urandom_range(0, 9) < 4);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      rst_n   = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      #1;
      if (!rst_n) begin
        n_assert++;
        if (s_ready_o !== 4'b0000 || grant_valid_o !== 1'b0 || grant_idx_o !== 2'd0) begin
          n_fail++;
          $display("FAIL random_reset cycle %0d: got ready=%b gv=%b idx=%0d expected all zero", c, s_ready_o, grant_valid_o, grant_idx_o);
        end
        model_reset();
      end else begin
        exp_r = model_ready();
        n_assert++;
        if (s_ready_o !== exp_r) begin
          n_fail++; $display("FAIL random_ready cycle %0d: got %b expected %b", c, s_ready_o, exp_r);
        end
        n_assert++;
        if (grant_valid_o !== (m_owner >= 0)) begin
          n_fail++; $display("FAIL random_grant_valid cycle %0d: got %b expected %b", c, grant_valid_o, (m_owner >= 0));
        end
        if (m_owner >= 0) begin
          n_assert++;
          if (grant_idx_o !== 2'(m_owner)) begin
            n_fail++; $display("FAIL random_grant_idx cycle %0d: got %0d expected %0d", c, grant_idx_o, m_owner);
          end
        end
        model_advance();
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    number    = 2'd0;
    m_ready   = 1'b0;
    s_dest_i  = 8'h00;
    s_valid_i = 4'b0000;
    s_last    = 4'b0000;
    weight_i  = '0;
    model_reset();
    #1;
    test_reset();
    test_handoff();
    test_alternate();
    test_weight();
    test_stall();
    test_no_match();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
